// File: rtl/ship_bullet_engine.sv
// Game-object engine for the VGA mini-game: ship position, a bullet pool, tick-divided
// motion, edge-triggered firing with cooldown, pause, and registered per-pixel colour.
module ship_bullet_engine #(
    parameter int H_RES         = 640,
    parameter int N_BULLETS     = 8,
    parameter int SHIP_W        = 16,
    parameter int SHIP_H        = 16,
    parameter int SHIP_Y        = 450,
    parameter int SHIP_STEP     = 5,
    parameter int BULLET_W      = 4,
    parameter int BULLET_H      = 8,
    parameter int BULLET_STEP   = 5,
    parameter int MOVE_DIV      = 1000000,
    parameter int BULLET_DIV    = 100000,
    parameter int FIRE_COOLDOWN = 4
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 fire,
    input  logic                 pause,
    input  logic [9:0]           pixel_x,
    input  logic [8:0]           pixel_y,
    input  logic                 pixel_valid,
    output logic [7:0]           r_data,
    output logic [7:0]           g_data,
    output logic [7:0]           b_data,
    output logic [9:0]           ship_x,
    output logic [N_BULLETS-1:0] bullets_active,
    output logic [15:0]          shots_fired
);

    localparam int MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int BCW = (BULLET_DIV > 1) ? $clog2(BULLET_DIV) : 1;
    localparam int CDW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

    localparam logic [MCW-1:0]       MOVE_LAST   = MCW'(MOVE_DIV - 1);
    localparam logic [BCW-1:0]       BULLET_LAST = BCW'(BULLET_DIV - 1);
    localparam logic [CDW-1:0]       CD_LOAD     = CDW'(FIRE_COOLDOWN);
    localparam logic [9:0]           SHIP_X0     = 10'((H_RES - SHIP_W) / 2);
    localparam logic [9:0]           X_MAX       = 10'(H_RES - SHIP_W);
    localparam logic [9:0]           S_STEP      = 10'(SHIP_STEP);
    localparam logic [9:0]           SPAWN_DX    = 10'(SHIP_W / 2 - BULLET_W / 2);
    localparam logic [8:0]           SPAWN_Y     = 9'(SHIP_Y - BULLET_H);
    localparam logic [8:0]           B_STEP      = 9'(BULLET_STEP);
    localparam logic [N_BULLETS-1:0] ONE_N       = N_BULLETS'(1);

    logic [MCW-1:0]       move_cnt_r, move_cnt_s;
    logic [BCW-1:0]       bullet_cnt_r, bullet_cnt_s;
    logic                 move_tick_s, bullet_tick_s;
    logic [9:0]           ship_x_r, ship_x_s;
    logic [9:0]           bx_r [N_BULLETS];
    logic [9:0]           bx_s [N_BULLETS];
    logic [8:0]           by_r [N_BULLETS];
    logic [8:0]           by_s [N_BULLETS];
    logic [N_BULLETS-1:0] active_r, active_s, free_s, alloc_oh_s;
    logic [CDW-1:0]       cd_r, cd_s;
    logic                 fire_q_r, fire_event_s, alloc_s;
    logic [15:0]          shots_r, shots_s;
    logic [10:0]          px_s, py_s;
    logic                 hit_ship_s, hit_bullet_s;
    logic [7:0]           r_r, g_r, b_r;

    assign ship_x         = ship_x_r;
    assign bullets_active = active_r;
    assign shots_fired    = shots_r;
    assign r_data         = r_r;
    assign g_data         = g_r;
    assign b_data         = b_r;

    // Next-state logic: tick dividers, ship motion, firing, bullet motion, cooldown.
    always_comb begin
        move_tick_s   = 1'b0;
        bullet_tick_s = 1'b0;
        move_cnt_s    = move_cnt_r;
        bullet_cnt_s  = bullet_cnt_r;
        if (!pause) begin
            if (move_cnt_r == MOVE_LAST) begin
                move_tick_s = 1'b1;
                move_cnt_s  = '0;
            end else begin
                move_cnt_s = move_cnt_r + MCW'(1);
            end
            if (bullet_cnt_r == BULLET_LAST) begin
                bullet_tick_s = 1'b1;
                bullet_cnt_s  = '0;
            end else begin
                bullet_cnt_s = bullet_cnt_r + BCW'(1);
            end
        end else begin
            move_cnt_s   = move_cnt_r;
            bullet_cnt_s = bullet_cnt_r;
        end

        ship_x_s = ship_x_r;
        if (move_tick_s && move_left && !move_right) begin
            if (ship_x_r >= S_STEP) ship_x_s = ship_x_r - S_STEP;
            else                    ship_x_s = 10'd0;
        end else if (move_tick_s && move_right && !move_left) begin
            if (({1'b0, ship_x_r} + {1'b0, S_STEP}) <= {1'b0, X_MAX}) ship_x_s = ship_x_r + S_STEP;
            else                                                      ship_x_s = X_MAX;
        end else begin
            ship_x_s = ship_x_r;
        end

        // Lowest free slot as a one-hot: free & -free, where -free == active + 1.
        free_s       = ~active_r;
        alloc_oh_s   = free_s & (active_r + ONE_N);
        fire_event_s = fire & ~fire_q_r & ~pause & (cd_r == '0);
        alloc_s      = fire_event_s & (|free_s);

        active_s = active_r;
        for (int i = 0; i < N_BULLETS; i++) begin
            bx_s[i] = bx_r[i];
            by_s[i] = by_r[i];
            if (alloc_s && alloc_oh_s[i]) begin
                active_s[i] = 1'b1;
                bx_s[i]     = ship_x_r + SPAWN_DX;
                by_s[i]     = SPAWN_Y;
            end else if (bullet_tick_s && active_r[i]) begin
                if (by_r[i] >= B_STEP) by_s[i] = by_r[i] - B_STEP;
                else                   active_s[i] = 1'b0;
            end else begin
                by_s[i] = by_r[i];
            end
        end

        if (alloc_s)                          cd_s = CD_LOAD;
        else if (bullet_tick_s && cd_r != '0) cd_s = cd_r - CDW'(1);
        else                                  cd_s = cd_r;

        if (alloc_s && shots_r != 16'hFFFF) shots_s = shots_r + 16'd1;
        else                                shots_s = shots_r;
    end

    // Hit tests against the registered object state, widened to 11 bits so edges never wrap.
    always_comb begin
        px_s         = {1'b0, pixel_x};
        py_s         = {2'b00, pixel_y};
        hit_ship_s   = (px_s >= {1'b0, ship_x_r}) && (px_s < ({1'b0, ship_x_r} + 11'(SHIP_W))) &&
                       (py_s >= 11'(SHIP_Y)) && (py_s < 11'(SHIP_Y + SHIP_H));
        hit_bullet_s = 1'b0;
        for (int i = 0; i < N_BULLETS; i++) begin
            if (active_r[i] &&
                (px_s >= {1'b0, bx_r[i]}) && (px_s < ({1'b0, bx_r[i]} + 11'(BULLET_W))) &&
                (py_s >= {2'b00, by_r[i]}) && (py_s < ({2'b00, by_r[i]} + 11'(BULLET_H)))) begin
                hit_bullet_s = 1'b1;
            end else begin
                hit_bullet_s = hit_bullet_s;
            end
        end
    end

    // Object state registers.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            move_cnt_r   <= '0;
            bullet_cnt_r <= '0;
            ship_x_r     <= SHIP_X0;
            active_r     <= '0;
            cd_r         <= '0;
            fire_q_r     <= 1'b0;
            shots_r      <= 16'd0;
            for (int i = 0; i < N_BULLETS; i++) begin
                bx_r[i] <= 10'd0;
                by_r[i] <= 9'd0;
            end
        end else begin
            move_cnt_r   <= move_cnt_s;
            bullet_cnt_r <= bullet_cnt_s;
            ship_x_r     <= ship_x_s;
            active_r     <= active_s;
            cd_r         <= cd_s;
            fire_q_r     <= fire;
            shots_r      <= shots_s;
            for (int i = 0; i < N_BULLETS; i++) begin
                bx_r[i] <= bx_s[i];
                by_r[i] <= by_s[i];
            end
        end
    end

    // Registered colour with ship over bullet priority; ship dims while paused.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_r <= 8'h00; g_r <= 8'h00; b_r <= 8'h00;
        end else if (!pixel_valid) begin
            r_r <= 8'h00; g_r <= 8'h00; b_r <= 8'h00;
        end else if (hit_ship_s) begin
            r_r <= 8'h00; g_r <= pause ? 8'h80 : 8'hFF; b_r <= 8'h00;
        end else if (hit_bullet_s) begin
            r_r <= 8'h00; g_r <= 8'hFF; b_r <= 8'hFF;
        end else begin
            r_r <= 8'h00; g_r <= 8'h00; b_r <= 8'h00;
        end
    end

endmodule

// File: tb/tb_ship_bullet_engine.sv
// Directed self-checking bench for ship_bullet_engine with MOVE_DIV=4, BULLET_DIV=2, N_BULLETS=4.
module tb_ship_bullet_engine;

    logic        vga_clk = 1'b0;
    logic        reset, move_left, move_right, fire, pause, pixel_valid;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [7:0]  r_data, g_data, b_data;
    logic [9:0]  ship_x;
    logic [3:0]  bullets_active;
    logic [15:0] shots_fired;
    int          checks = 0;
    int          errors = 0;

    always #5 vga_clk = ~vga_clk;

    ship_bullet_engine #(
        .N_BULLETS(4), .MOVE_DIV(4), .BULLET_DIV(2)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .move_left(move_left), .move_right(move_right),
        .fire(fire), .pause(pause), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .r_data(r_data), .g_data(g_data), .b_data(b_data),
        .ship_x(ship_x), .bullets_active(bullets_active), .shots_fired(shots_fired)
    );

    task automatic step(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        pixel_x     = 10'(x);
        pixel_y     = 9'(y);
        pixel_valid = v;
    endtask

    task automatic do_reset();
        reset = 1'b1; move_left = 1'b0; move_right = 1'b0; fire = 1'b0; pause = 1'b0;
        set_pix(0, 0, 1'b0);
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; move_left = 1'b0; move_right = 1'b0; fire = 1'b0; pause = 1'b0;
        set_pix(312, 450, 1'b1);
        step(2);
        checks++; if (ship_x !== 10'd312) begin errors++; $display("FAIL reset_ship_x: got %0d expected 312", ship_x); end
        checks++; if (bullets_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b expected 0000", bullets_active); end
        checks++; if (shots_fired !== 16'd0) begin errors++; $display("FAIL reset_shots: got %0d expected 0", shots_fired); end
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL reset_colour: got %h expected 000000", {r_data, g_data, b_data}); end
        reset = 1'b0;
    endtask

    task automatic test_ship_clamp();
        do_reset();
        move_left = 1'b1;
        step(4);
        checks++; if (ship_x !== 10'd307) begin errors++; $display("FAIL left_first_tick: got %0d expected 307", ship_x); end
        step(244);
        checks++; if (ship_x !== 10'd2) begin errors++; $display("FAIL left_62_ticks: got %0d expected 2", ship_x); end
        step(4);
        checks++; if (ship_x !== 10'd0) begin errors++; $display("FAIL left_clamp: got %0d expected 0", ship_x); end
        step(28);
        checks++; if (ship_x !== 10'd0) begin errors++; $display("FAIL left_hold_zero: got %0d expected 0", ship_x); end
        move_left = 1'b0; move_right = 1'b1;
        step(4);
        checks++; if (ship_x !== 10'd5) begin errors++; $display("FAIL right_first_tick: got %0d expected 5", ship_x); end
        step(496);
        checks++; if (ship_x !== 10'd624) begin errors++; $display("FAIL right_clamp: got %0d expected 624", ship_x); end
        step(20);
        checks++; if (ship_x !== 10'd624) begin errors++; $display("FAIL right_hold_max: got %0d expected 624", ship_x); end
        move_left = 1'b1;
        step(8);
        checks++; if (ship_x !== 10'd624) begin errors++; $display("FAIL both_pressed: got %0d expected 624", ship_x); end
        move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic test_fire_hold();
        do_reset();
        fire = 1'b1;
        step(1);
        checks++; if (bullets_active !== 4'b0001) begin errors++; $display("FAIL fire_slot0: got %b expected 0001", bullets_active); end
        checks++; if (shots_fired !== 16'd1) begin errors++; $display("FAIL fire_count: got %0d expected 1", shots_fired); end
        set_pix(318, 442, 1'b1);
        step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FFFF) begin errors++; $display("FAIL spawn_pos: got %h expected 00ffff", {r_data, g_data, b_data}); end
        step(18);
        checks++; if (shots_fired !== 16'd1) begin errors++; $display("FAIL fire_held_once: got %0d expected 1", shots_fired); end
        checks++; if (bullets_active !== 4'b0001) begin errors++; $display("FAIL fire_held_active: got %b expected 0001", bullets_active); end
        fire = 1'b0;
    endtask

    task automatic test_fire_cooldown();
        do_reset();
        fire = 1'b1; step(1);
        fire = 1'b0; step(1);
        fire = 1'b1; step(1);
        checks++; if (shots_fired !== 16'd1) begin errors++; $display("FAIL cooldown_block: got %0d expected 1", shots_fired); end
        checks++; if (bullets_active !== 4'b0001) begin errors++; $display("FAIL cooldown_active: got %b expected 0001", bullets_active); end
        fire = 1'b0; step(5);
        fire = 1'b1; step(1);
        checks++; if (bullets_active !== 4'b0011) begin errors++; $display("FAIL after_cooldown_slot1: got %b expected 0011", bullets_active); end
        checks++; if (shots_fired !== 16'd2) begin errors++; $display("FAIL after_cooldown_count: got %0d expected 2", shots_fired); end
        fire = 1'b0;
    endtask

    task automatic test_pool_full();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fire = 1'b1; step(1);
            fire = 1'b0; step(9);
        end
        checks++; if (bullets_active !== 4'b1111) begin errors++; $display("FAIL pool_full_active: got %b expected 1111", bullets_active); end
        checks++; if (shots_fired !== 16'd4) begin errors++; $display("FAIL pool_full_count: got %0d expected 4", shots_fired); end
        step(127);
        checks++; if (bullets_active !== 4'b1111) begin errors++; $display("FAIL slot0_at_y2: got %b expected 1111", bullets_active); end
        step(1);
        checks++; if (bullets_active !== 4'b1110) begin errors++; $display("FAIL slot0_expired: got %b expected 1110", bullets_active); end
    endtask

    task automatic test_pause();
        do_reset();
        fire = 1'b1; step(1);
        fire = 1'b0; step(2);
        pause = 1'b1; move_left = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fire = 1'b1; step(2);
            fire = 1'b0; step(3);
        end
        fire = 1'b1; step(1);
        checks++; if (ship_x !== 10'd312) begin errors++; $display("FAIL pause_ship_frozen: got %0d expected 312", ship_x); end
        checks++; if (shots_fired !== 16'd1) begin errors++; $display("FAIL pause_no_fire: got %0d expected 1", shots_fired); end
        checks++; if (bullets_active !== 4'b0001) begin errors++; $display("FAIL pause_active: got %b expected 0001", bullets_active); end
        set_pix(312, 450, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h008000) begin errors++; $display("FAIL pause_ship_dim: got %h expected 008000", {r_data, g_data, b_data}); end
        set_pix(318, 437, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FFFF) begin errors++; $display("FAIL pause_bullet_frozen: got %h expected 00ffff", {r_data, g_data, b_data}); end
        set_pix(318, 445, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL pause_bullet_bottom: got %h expected 000000", {r_data, g_data, b_data}); end
        pause = 1'b0;
        step(1);
        checks++; if (ship_x !== 10'd307) begin errors++; $display("FAIL unpause_counter_held: got %0d expected 307", ship_x); end
        checks++; if (shots_fired !== 16'd1) begin errors++; $display("FAIL unpause_fire_held: got %0d expected 1", shots_fired); end
        move_left = 1'b0;
        set_pix(318, 432, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FFFF) begin errors++; $display("FAIL unpause_bullet_moved: got %h expected 00ffff", {r_data, g_data, b_data}); end
        fire = 1'b0;
    endtask

    task automatic test_reset_midflight();
        pause = 1'b1; fire = 1'b1; move_right = 1'b1; reset = 1'b1;
        set_pix(312, 450, 1'b1);
        step(1);
        reset = 1'b0; pause = 1'b0; fire = 1'b0; move_right = 1'b0;
        checks++; if (ship_x !== 10'd312) begin errors++; $display("FAIL midflight_ship: got %0d expected 312", ship_x); end
        checks++; if (bullets_active !== 4'b0000) begin errors++; $display("FAIL midflight_active: got %b expected 0000", bullets_active); end
        checks++; if (shots_fired !== 16'd0) begin errors++; $display("FAIL midflight_shots: got %0d expected 0", shots_fired); end
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL midflight_colour: got %h expected 000000", {r_data, g_data, b_data}); end
    endtask

    task automatic test_render();
        do_reset();
        set_pix(312, 450, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FF00) begin errors++; $display("FAIL render_ship: got %h expected 00ff00", {r_data, g_data, b_data}); end
        set_pix(0, 0, 1'b1); #1;
        checks++; if ({r_data, g_data, b_data} !== 24'h00FF00) begin errors++; $display("FAIL render_latency_hold: got %h expected 00ff00", {r_data, g_data, b_data}); end
        set_pix(327, 465, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FF00) begin errors++; $display("FAIL render_ship_corner: got %h expected 00ff00", {r_data, g_data, b_data}); end
        set_pix(328, 450, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL render_ship_right_edge: got %h expected 000000", {r_data, g_data, b_data}); end
        set_pix(312, 466, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL render_ship_bottom_edge: got %h expected 000000", {r_data, g_data, b_data}); end
        set_pix(312, 450, 1'b0); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL render_invalid: got %h expected 000000", {r_data, g_data, b_data}); end
        do_reset();
        fire = 1'b1; step(1);
        fire = 1'b0;
        set_pix(318, 442, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FFFF) begin errors++; $display("FAIL render_bullet: got %h expected 00ffff", {r_data, g_data, b_data}); end
        set_pix(322, 440, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h000000) begin errors++; $display("FAIL render_bullet_right_edge: got %h expected 000000", {r_data, g_data, b_data}); end
        set_pix(321, 444, 1'b1); step(1);
        checks++; if ({r_data, g_data, b_data} !== 24'h00FFFF) begin errors++; $display("FAIL render_bullet_corner: got %h expected 00ffff", {r_data, g_data, b_data}); end
    endtask

    initial begin
        test_reset();
        test_ship_clamp();
        test_fire_hold();
        test_fire_cooldown();
        test_pool_full();
        test_pause();
        test_reset_midflight();
        test_render();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ship_bullet_engine.md
# ship_bullet_engine

Parametrised game-object engine for the VGA mini-game, sitting between the PS/2 control decode and the VGA colour outputs. It owns the player ship position and a pool of `N_BULLETS` projectiles, and provides tick-divided motion, edge-triggered firing with cooldown, and pause. It renders ship and bullets for the pixel coordinate supplied by the sync/address path, with a registered colour output.

## Interface
Parameters:
- `H_RES`, 640, visible width in pixels
- `N_BULLETS`, 8, bullet pool size (1..16)
- `SHIP_W` / `SHIP_H`, 16 / 16, ship size in pixels
- `SHIP_Y`, 450, fixed ship top row
- `SHIP_STEP`, 5, ship pixels moved per move tick
- `BULLET_W` / `BULLET_H`, 4 / 8, bullet size in pixels
- `BULLET_STEP`, 5, bullet pixels moved per bullet tick
- `MOVE_DIV`, 1000000, clocks per move tick
- `BULLET_DIV`, 100000, clocks per bullet tick
- `FIRE_COOLDOWN`, 4, bullet ticks after a shot before the next allowed shot

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `vga_clk`, in, 1, pixel clock; all state on rising edge.
  - `reset`, in, 1, synchronous, active-high.
- `move_left`, `move_right`, `fire`, `pause`, in, 1 each, level controls.
- `pixel_x`, in, 10, current pixel column.
- `pixel_y`, in, 9, current pixel row.
- `pixel_valid`, in, 1, visible-area qualifier.
- `r_data`, `g_data`, `b_data`, out, 8 each, registered colour.
- `ship_x`, out, 10, ship left column.
- `bullets_active`, out, `N_BULLETS`, per-slot active flags.
- `shots_fired`, out, 16, count of allocated shots; saturates at 0xFFFF.

## Operation
- **Reset.**
  - `ship_x` = (H_RES−SHIP_W)/2, which is 312 with default parameters.
  - All bullet slots inactive, with x = 0 and y = 0.
  - Divider counters, cooldown, `fire_q` and `shots_fired` are 0.
  - `r_data`, `g_data` and `b_data` are 0.
- **Tick generation.**
  - The move counter counts 0..MOVE_DIV−1. It asserts `move_tick` for one clock when it equals MOVE_DIV−1, then wraps to 0.
  - The bullet counter works the same way with BULLET_DIV.
  - While `pause` = 1, both counters hold and no ticks occur.
- **Ship motion (on `move_tick`).**
  - Left only: x ≥ SHIP_STEP gives x − SHIP_STEP; otherwise x becomes 0.
  - Right only: x + SHIP_STEP ≤ H_RES−SHIP_W gives x + SHIP_STEP; otherwise x becomes H_RES−SHIP_W.
  - Both or neither pressed: x holds.
- **Firing.**
  - `fire_q` registers `fire` every clock, including during pause.
  - A fire event is `fire & ~fire_q & ~pause & (cooldown == 0)`.
  - A fire event allocates the lowest-index slot that was inactive at the start of the cycle:
    - x = ship_x + SHIP_W/2 − BULLET_W/2
    - y = SHIP_Y − BULLET_H
    - the slot becomes active, cooldown loads FIRE_COOLDOWN, and `shots_fired` increments.
  - No free slot: the event is dropped; no counter or cooldown change.
- **Bullet motion (on `bullet_tick`).**
  - Each slot that was active at the start of the cycle: y ≥ BULLET_STEP gives y − BULLET_STEP; otherwise the slot deactivates.
  - Cooldown decrements if nonzero.
- **Simultaneous events.** A fire event and a `bullet_tick` in the same cycle:
  - The newly allocated slot does not move that cycle.
  - A slot freed by this tick is not eligible until the next cycle.
  - Cooldown takes the loaded value; the load wins over the decrement.
- **Rendering.**
  - `hit_ship`: pixel inside [ship_x, ship_x+SHIP_W) × [SHIP_Y, SHIP_Y+SHIP_H).
  - `hit_bullet`: OR over active slots of pixel inside [x, x+BULLET_W) × [y, y+BULLET_H).
  - Compare in 11-bit arithmetic; no wrap.
  - Colour priority, as (R,G,B):
    - `pixel_valid` = 0 → (00,00,00)
    - ship → (00,FF,00); (00,80,00) while paused
    - bullet → (00,FF,FF)
    - otherwise → (00,00,00)

## Timing
- Colour output latency: one clock from `pixel_x`/`pixel_y`/`pixel_valid` to `r/g/b_data`. The caller aligns sync by one clock.
- Rendering uses object state as registered before the current edge. A position update becomes visible on the next pixel.
- Fire event to `bullets_active` bit high: one clock.
- Fire edge during pause is lost. Releasing pause while `fire` is held does not fire; a new 0→1 edge is required.
- Reset asserted mid-flight clears everything on the next edge regardless of tick or pause state.

## Test plan
Simulation parameters: MOVE_DIV=4, BULLET_DIV=2, N_BULLETS=4.
- **Reset:** reset 2 clocks.
  - `ship_x`=312, `bullets_active`=0, `shots_fired`=0.
  - colour=0 for any pixel.
- **Ship clamp:** `move_left` held for 70 move ticks.
  - `ship_x` steps 312→307…→2→0 and stays 0.
  - `move_right` held then reaches 624 and stays there.
  - Both pressed: no change.
- **Fire edge and cooldown:** `fire` held high for 20 clocks.
  - Exactly one shot: slot 0 at x=318, y=442; `shots_fired`=1.
  - Pulse `fire` again within 4 bullet ticks → ignored.
  - Pulse after cooldown → slot 1 allocated.
- **Pool full and expiry:**
  - Fire 5 spaced shots → 4 slots active; 5th dropped; `shots_fired`=4.
  - Slot 0 goes inactive on the tick after y reaches 2 (442→…→2, then y<5).
- **Pause:** assert `pause` for 50 clocks with `move_left` and fire pulses.
  - `ship_x`, bullet y and counters frozen; no allocation.
  - Ship pixel renders (00,80,00).
- **Render priority and latency:**
  - Pixel at (312,450) gives (00,FF,00) one clock later.
  - Bullet-only pixel gives (00,FF,FF).
  - `pixel_valid`=0 gives 0.
